uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DEFAULT_DIV, default 106, reset value of the bit-period divider in clk cycles.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ser_rx  input  1  asynchronous serial line; 8N1, LSB first, idle high.
REQ-006 cfg_div_we  input  1  divider write strobe.
REQ-007 cfg_div_wdata  input  32  divider write value.
REQ-008 cfg_div  output  32  current divider value.
REQ-009 rd_valid  output  1  FIFO non-empty.
REQ-010 rd_ready  input  1  consumer pop; a pop occurs when rd_valid and rd_ready are both high.
REQ-011 rd_data  output  8  FIFO head byte; valid only while rd_valid is high.
REQ-012 frame_err  output  1  sticky; stop bit sampled low.
REQ-013 overrun  output  1  sticky; byte dropped because the FIFO was full.
REQ-014 parity_err  output  1  sticky; parity mismatch (tied 0 without UART_RX_PARITY_EN).
REQ-015 err_clr  input  1  clears all three sticky flags.

Function
REQ-016 ser_rx shall pass through a 2-flop synchronizer before any use; rx_s denotes the synchronized value.
REQ-017 FSM states shall be IDLE, START, DATA, PARITY (only with UART_RX_PARITY_EN) and STOP.
REQ-018 IDLE: rx_s==0 shall latch cfg_div into div_q, clear the bit counter and enter START.
REQ-019 START: at counter==div_q/2-1, sample rx_s; if 1, return to IDLE (glitch) with no flags set; if 0, clear the counter and enter DATA.
REQ-020 DATA: at each counter==div_q-1, shift rx_s into bit 7 of the shift register (LSB first); after 8 bits, enter PARITY or STOP.
REQ-021 PARITY: at counter==div_q-1, compute even parity over data plus the parity bit; set parity_err on mismatch and mark the byte for discard.
REQ-022 STOP: at counter==div_q-1, sample rx_s; if 0, set frame_err and discard the byte; if 1 and not discarded, push the byte; then return to IDLE.
REQ-023 A push when the FIFO is full with no pop in the same cycle shall drop the byte and set overrun.
REQ-024 A push on a full FIFO with a pop in the same cycle shall be accepted, with no overrun.
REQ-025 rd_valid shall rise on the cycle after the push; FIFO occupancy shall never exceed FIFO_DEPTH.
REQ-026 A cfg_div write with cfg_div_wdata<4 shall store 4.
REQ-027 A cfg_div write mid-frame shall take effect only at the next start bit (div_q is unchanged).
REQ-028 If err_clr and a flag-set event occur in the same cycle, the set shall win.
REQ-029 Read and write pointers shall be log2(FIFO_DEPTH)+1 bits wide, wrap naturally, and distinguish full from empty by the MSB.

Reset
REQ-030 Reset shall force: synchronizer flops=1, state=IDLE, counters=0, FIFO empty, cfg_div=DEFAULT_DIV, rd_valid=0, rd_data=0, all error flags=0.
REQ-031 Reset asserted mid-frame shall abandon the frame with no push and no flag set.
REQ-032 After reset deasserts, the next falling edge on ser_rx shall start reception normally.

Configuration
REQ-033 With macro UART_RX_PARITY_EN defined, each frame shall carry one even-parity bit between data and stop, and the PARITY state and parity_err shall be active.
REQ-034 Without UART_RX_PARITY_EN, frames shall be 8N1, the PARITY state shall be absent, and parity_err shall be constant 0.

Structure
REQ-035 Shared package uart_pkg shall hold the FSM state typedef, the MIN_DIV=4 constant and the DATA_BITS=8 constant.
REQ-036 The FIFO shall be a separate sub-module uart_rx_fifo (parameterized by depth, push/pop/full/empty interface).

Verification
REQ-037 cfg_div=106; send 0x55 -> rd_valid rises about 10*106 cycles after the start edge, rd_data=0x55, no flags set.
REQ-038 ser_rx low for 20 cycles only -> no push, no flags, FSM back in IDLE.
REQ-039 Send 0xA3 with the stop bit driven low -> frame_err=1, rd_valid stays 0; err_clr pulse -> frame_err=0.
REQ-040 Send 0x01..0x05 back-to-back with rd_ready=0 -> overrun=1; reads return 0x01, 0x02, 0x03, 0x04, then rd_valid=0.
REQ-041 Assert reset mid-byte, then send 0x7E -> exactly one byte received, 0x7E; cfg_div write of 2 reads back 4.
REQ-042 UART_RX_PARITY_EN: send 0x01 with parity bit 0 -> parity_err=1, no push; send 0x01 with parity bit 1 -> 0x01 received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared FSM state type and constants for the UART receiver.
// ST_PARITY exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int MIN_DIV   = 4;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

    // Very small divisors would leave no room for a mid-bit sample point.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with extra-MSB pointers; full and empty differ only in that MSB.
// The head is shown combinationally and reads as zero while the FIFO is empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic                 wr_en;
    logic                 rd_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_en = pop && !empty;
    // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
    assign wr_en = push && (!full || rd_en);
    assign dout  = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 when UART_RX_PARITY_EN is defined), mid-bit sampling,
// programmable bit divider, receive FIFO and sticky frame/overrun/parity flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV = 106,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ser_rx,
    input  logic        cfg_div_we,
    input  logic [31:0] cfg_div_wdata,
    output logic [31:0] cfg_div,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        frame_err,
    output logic        overrun,
    output logic        parity_err,
    input  logic        err_clr
);

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [31:0]          cnt;
    logic [31:0]          div_q;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 discard;
    logic                 push_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 ovr_evt;
    logic [31:0]          half_end;
    logic [31:0]          bit_end;

    assign half_end = (div_q >> 1) - 32'd1;
    assign bit_end  = div_q - 32'd1;
    assign rd_valid = !fifo_empty;
    assign pop      = rd_valid && rd_ready;
    assign ovr_evt  = push_q && fifo_full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= ser_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_div <= 32'(DEFAULT_DIV);
        end else if (cfg_div_we) begin
            cfg_div <= clamp_div(cfg_div_wdata);
        end
    end

    // Receive FSM; flag sets are written after the clear so a same-cycle set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            div_q     <= 32'(DEFAULT_DIV);
            discard   <= 1'b0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            if (err_clr) begin
                frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        div_q   <= cfg_div;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        discard <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == half_end) begin
                        cnt   <= '0;
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == bit_end) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt == bit_end) begin
                        cnt   <= '0;
                        state <= ST_STOP;
                        if (^{shreg, rx_s}) begin
                            parity_err <= 1'b1;
                            discard    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt == bit_end) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                        end else if (!discard) begin
                            push_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Data shifts in at bit 7 so the first (LSB) bit ends up in bit 0.
    always_ff @(posedge clk) begin
        if (state == ST_DATA && cnt == bit_end) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (ovr_evt) begin
            overrun <= 1'b1;
        end else if (err_clr) begin
            overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pop   (pop),
        .din   (shreg),
        .dout  (rd_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
